// File: rtl/spi_helpers_router_pkg.sv
// ---------------------------------------------------------------------------
// spi_helpers_router_pkg
//
// Shared definitions for the SPI minion router.
//   router_aw(np)        : address width needed to select one of np endpoints
//   router_dw(nbits, np) : payload width left after the address field
//   dn_entry_t           : downstream entry layout {addr, data}
//   up_entry_t           : upstream entry layout {src, data}
//
// The entry structs describe the layout of the default 8-bit frame,
// 4-endpoint build. The router itself slices messages with widths derived
// from its own parameters, so other configurations use the same field order.
// ---------------------------------------------------------------------------
package spi_helpers_router_pkg;

    localparam int MAX_PORTS = 16;

    function automatic int router_aw(input int np);
        return $clog2(np);
    endfunction

    function automatic int router_dw(input int nbits, input int np);
        return (nbits - 2) - $clog2(np);
    endfunction

    localparam int DEF_NBITS     = 8;
    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_AW        = router_aw(DEF_NUM_PORTS);
    localparam int DEF_DW        = router_dw(DEF_NBITS, DEF_NUM_PORTS);

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } dn_entry_t;

    typedef struct packed {
        logic [DEF_AW-1:0] src;
        logic [DEF_DW-1:0] data;
    } up_entry_t;

endpackage

// File: rtl/spi_helpers_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_helpers_rr_arbiter
//
// Round-robin arbiter. The grant is the first request found at or after the
// internal pointer, searching cyclically. The pointer moves to one past the
// granted index whenever en is high and at least one request is present.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> 0)
//   req          : request vector, one bit per port
//   en           : the granted request is consumed this cycle
//   grant        : one-hot grant (all zero when no request)
//   grant_idx    : binary index of the granted port
// ---------------------------------------------------------------------------
module spi_helpers_rr_arbiter
    import spi_helpers_router_pkg::*;
#(
    parameter  int num_ports = 4,
    localparam int AW        = router_aw(num_ports)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [num_ports-1:0] req,
    input  logic                 en,
    output logic [num_ports-1:0] grant,
    output logic [AW-1:0]        grant_idx
);

    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] ptr_next;
    logic          any_req;

    // Cyclic priority search starting at the pointer.
    always_comb begin
        int          idx;
        logic [AW-1:0] idx_l;
        idx       = 0;
        idx_l     = '0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = 0; k < num_ports; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= num_ports) begin
                idx = idx - num_ports;
            end
            idx_l = AW'(idx);
            if (!any_req && req[idx_l]) begin
                any_req          = 1'b1;
                grant[idx_l]     = 1'b1;
                grant_idx        = idx_l;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (en && any_req) begin
            ptr_next = (grant_idx == AW'(num_ports - 1)) ? '0 : grant_idx + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/spi_helpers_minion_router.sv
// ---------------------------------------------------------------------------
// spi_helpers_minion_router
//
// Connects the SPI minion adapter's val/rdy channels to num_ports endpoints.
//   Downstream: dn_msg = {addr, data} is steered to endpoint addr through a
//               one-entry register (1-cycle latency, full throughput).
//               Addresses >= num_ports are accepted and dropped.
//   Upstream:   endpoint responses are arbitrated round-robin, tagged with
//               the source index and presented as up_msg = {src, data}.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   dn_msg/dn_val/dn_rdy    : from adapter send channel (W = nbits-2 bits)
//   ep_msg/ep_val/ep_rdy    : to endpoints, shared data, one-hot valid
//   rsp_msg/rsp_val/rsp_rdy : from endpoints, port i at [i*DW +: DW]
//   up_msg/up_val/up_rdy    : to adapter recv channel
//   drop_cnt                : saturating count of dropped messages, only
//                             present when SPI_HELPERS_ROUTER_DROP_CNT_EN
//                             is defined
// ---------------------------------------------------------------------------
module spi_helpers_minion_router
    import spi_helpers_router_pkg::*;
#(
    parameter  int nbits     = 8,
    parameter  int num_ports = 4,
    localparam int W         = nbits - 2,
    localparam int AW        = router_aw(num_ports),
    localparam int DW        = router_dw(nbits, num_ports)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [W-1:0]            dn_msg,
    input  logic                    dn_val,
    output logic                    dn_rdy,
    output logic [DW-1:0]           ep_msg,
    output logic [num_ports-1:0]    ep_val,
    input  logic [num_ports-1:0]    ep_rdy,
    input  logic [num_ports*DW-1:0] rsp_msg,
    input  logic [num_ports-1:0]    rsp_val,
    output logic [num_ports-1:0]    rsp_rdy,
    output logic [W-1:0]            up_msg,
    output logic                    up_val,
    input  logic                    up_rdy
`ifdef SPI_HELPERS_ROUTER_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);

    genvar gi;

    if (DW < 1) begin : g_dw_check
        $error("spi_helpers_minion_router: nbits too small for num_ports (DW < 1)");
    end
    if (num_ports < 2 || num_ports > MAX_PORTS) begin : g_ports_check
        $error("spi_helpers_minion_router: num_ports must be in 2..16");
    end

    // -----------------------------------------------------------------------
    // Downstream path
    // -----------------------------------------------------------------------
    logic          dn_full_reg;
    logic [AW-1:0] dn_addr_reg;
    logic [DW-1:0] dn_data_reg;

    logic [AW-1:0] dn_addr;
    logic [DW-1:0] dn_data;
    logic          dn_addr_ok;
    logic          dn_drain;
    logic          dn_accept;

    assign dn_addr = dn_msg[W-1:DW];
    assign dn_data = dn_msg[DW-1:0];

    // Every address is routable when num_ports fills the address space.
    if ((1 << AW) == num_ports) begin : g_addr_all_ok
        assign dn_addr_ok = 1'b1;
    end else begin : g_addr_range
        localparam logic [AW:0] PORT_LIMIT = num_ports[AW:0];
        assign dn_addr_ok = ({1'b0, dn_addr} < PORT_LIMIT);
    end

    // Only routable addresses are ever stored, so the decode is one-hot.
    for (gi = 0; gi < num_ports; gi++) begin : g_ep_val
        assign ep_val[gi] = dn_full_reg && (dn_addr_reg == AW'(gi));
    end

    assign ep_msg    = dn_data_reg;
    assign dn_drain  = |(ep_val & ep_rdy);
    // No handshake completes while reset is held; ready passes through on
    // a same-cycle drain so a stream moves at one message per cycle.
    assign dn_rdy    = reset_n & (~dn_full_reg | dn_drain);
    assign dn_accept = dn_val & dn_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dn_full_reg <= 1'b0;
            dn_addr_reg <= '0;
            dn_data_reg <= '0;
        end else begin
            if (dn_accept) begin
                // An unroutable message is consumed but leaves the slot empty.
                dn_full_reg <= dn_addr_ok;
                if (dn_addr_ok) begin
                    dn_addr_reg <= dn_addr;
                    dn_data_reg <= dn_data;
                end
            end else if (dn_drain) begin
                dn_full_reg <= 1'b0;
            end
        end
    end

`ifdef SPI_HELPERS_ROUTER_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_reg <= 8'd0;
        end else if (dn_accept && !dn_addr_ok && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    // -----------------------------------------------------------------------
    // Upstream path
    // -----------------------------------------------------------------------
    logic          up_full_reg;
    logic [AW-1:0] up_src_reg;
    logic [DW-1:0] up_data_reg;

    logic                 up_load;
    logic                 rsp_any;
    logic [num_ports-1:0] grant;
    logic [AW-1:0]        grant_idx;
    logic [DW-1:0]        rsp_masked [num_ports];
    logic [DW-1:0]        rsp_sel;

    assign up_load = reset_n & (~up_full_reg | up_rdy);
    assign rsp_any = |rsp_val;

    spi_helpers_rr_arbiter #(
        .num_ports (num_ports)
    ) u_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (rsp_val),
        .en        (up_load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign rsp_rdy = grant & {num_ports{up_load}};

    // One-hot AND-OR select of the granted response data.
    for (gi = 0; gi < num_ports; gi++) begin : g_rsp_mask
        assign rsp_masked[gi] = grant[gi] ? rsp_msg[gi*DW +: DW] : '0;
    end

    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < num_ports; i++) begin
            rsp_sel = rsp_sel | rsp_masked[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_full_reg <= 1'b0;
            up_src_reg  <= '0;
            up_data_reg <= '0;
        end else if (up_load) begin
            up_full_reg <= rsp_any;
            if (rsp_any) begin
                up_src_reg  <= grant_idx;
                up_data_reg <= rsp_sel;
            end
        end
    end

    assign up_val = up_full_reg;
    assign up_msg = {up_src_reg, up_data_reg};

endmodule

// File: doc/spi_helpers_minion_router.md
Name: spi_helpers_minion_router

Overview:
Routes the SPI minion adapter's val/rdy channels between several on-chip endpoints. Downstream, messages from the adapter's send channel are steered to one of num_ports endpoints by an address field. Upstream, responses from the endpoints are arbitrated round-robin, tagged with the source index and presented to the adapter's recv channel. Each direction has a one-entry pipeline register, giving full throughput with 1-cycle latency.

Parameters:
nbits, 8, SPI frame width; the message width is W = nbits-2, matching the adapter.
num_ports, 4, number of endpoints (2..16).
Derived: AW = $clog2(num_ports), DW = W-AW; DW must be >= 1, enforced by an elaboration-time check.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
dn_msg  input  W  from adapter send_msg; bits [W-1:DW] are the address, [DW-1:0] the data
dn_val  input  1  from adapter send_val
dn_rdy  output  1  to adapter send_rdy
ep_msg  output  DW  data to endpoints, shared by all ports
ep_val  output  num_ports  one-hot valid per endpoint
ep_rdy  input  num_ports  endpoint ready
rsp_msg  input  num_ports*DW  response data; port i occupies [i*DW +: DW]
rsp_val  input  num_ports  response valid
rsp_rdy  output  num_ports  response ready, at most one bit set
up_msg  output  W  to adapter recv_msg: {source index, data}
up_val  output  1  to adapter recv_val
up_rdy  input  1  from adapter recv_rdy

Behaviour:
Clock and reset:
- One clock domain.
- reset_n is asynchronous active-low, asserted asynchronously and released synchronously upstream.
- In reset: both pipeline registers are empty; ep_val=0, ep_msg=0, up_val=0, up_msg=0; round-robin pointer=0.
- Reset mid-transfer discards buffered messages. No partial state survives.

Downstream path:
- A transfer occurs when dn_val&dn_rdy.
- dn_rdy = ~dn_full | (ep_val[dn_addr_q] & ep_rdy[dn_addr_q]). Ready passes through on the same-cycle drain, so back-to-back messages move at 1/cycle.
- On accept with address < num_ports: the register loads the data and the address, dn_full=1 next cycle, and ep_val[addr]=1 (1-cycle latency).
- Address >= num_ports (non-power-of-2 num_ports): the message is accepted and dropped, with no ep_val pulse.
- ep_val is held with ep_msg stable until ep_rdy of that port. Other ports' ep_rdy are ignored.
- Simultaneous drain and accept: the register holds the new message; ep_val moves to the new port with no bubble.

Upstream path:
- Arbiter grant = first rsp_val[i] at or after ptr, searching cyclically.
- load = ~up_full | up_rdy.
- rsp_rdy[g] = load & rsp_val[g] for the granted g only; rsp_rdy is combinational from rsp_val/ptr/state.
- On load with any valid: up_msg <= {g[AW-1:0], rsp_msg[g]}, up_val=1 next cycle, ptr <= (g+1) mod num_ports.
- On load with none valid: up_val <= 0.
- up_val and up_msg are held stable until up_rdy.
- ptr changes only on a granted transfer.
- All ports continuously valid: grants rotate 0,1,2,3,0...

Independence:
- The two directions are fully independent.
- Simultaneous traffic in both directions never stalls either one.

Optional Feature:
SPI_HELPERS_ROUTER_DROP_CNT_EN
- Defined: adds output port drop_cnt [7:0], reset to 0. It increments on each accepted message with address >= num_ports and saturates at 255.
- Not defined: the port and counter are absent; dropping behaviour is unchanged.

Decomposition:
- Package spi_helpers_router_pkg holds:
  - localparam functions for AW/DW;
  - typedef packed struct dn_entry_t {addr, data};
  - typedef up_entry_t {src, data}.
- One sub-module: spi_helpers_rr_arbiter (parameter num_ports). Inputs req[num_ports], en. Outputs grant one-hot, grant_idx. The pointer lives inside and updates when en & |req.

Test Plan:
- Reset with dn_val=1, rsp_val=all-ones -> up_val=0, ep_val=0, rsp_rdy=0 during reset, and ptr=0 afterwards.
- nbits=8, num_ports=4: dn_msg=6'b10_1011, all ep_rdy=1 -> next cycle ep_val=4'b0100, ep_msg=4'b1011. A stream of 4 messages to ports 0,1,2,3 drains in 4 consecutive cycles.
- ep_rdy[2]=0 for 5 cycles with a message for port 2 buffered -> dn_rdy=0, and ep_msg and ep_val stay stable. Releasing ep_rdy[2] accepts the next dn_msg in the same cycle.
- rsp_val=4'b1111, up_rdy=1 -> up_msg sources 0,1,2,3,0; port 1 data 4'hA appears as up_msg=6'b01_1010.
- up_rdy=0 for 3 cycles -> up_msg is held and rsp_rdy=0. The grant after release continues the rotation with no port skipped.
- num_ports=3, macro defined: send address 3 twice -> no ep_val pulse, dn_rdy=1, drop_cnt=2. After 300 drops, drop_cnt=255.
